// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-locked round-robin arbiter feeding one AXI-Stream sink through a 2-entry output buffer
module axis_rr_arbiter #(
  parameter int NUM    = 4,
  parameter int DSIZE  = 8,
  parameter int IDSIZE = 2
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic [NUM*DSIZE-1:0] s_tdata,
  input  logic [NUM-1:0]       s_tvalid,
  input  logic [NUM-1:0]       s_tlast,
  output logic [NUM-1:0]       s_tready,
  output logic [DSIZE-1:0]     m_tdata,
  output logic                 m_tvalid,
  output logic                 m_tlast,
  input  logic                 m_tready,
  output logic [IDSIZE-1:0]    grant_id,
  output logic                 busy,
  output logic [15:0]          pkt_cnt
);
  typedef enum logic {IDLE, LOCK} state_t;
  state_t            r_state, w_state_nxt;
  logic [IDSIZE-1:0] r_ptr, r_grant, w_sel, w_idx;
  logic              w_any, w_push, w_pop, w_last_in;
  logic [DSIZE-1:0]  w_data_in;
  logic [1:0]        r_cnt;
  logic              r_head;
  logic [DSIZE:0]    r_mem [2];
  logic [15:0]       r_pkt_cnt;

  assign w_data_in = s_tdata[int'(r_grant)*DSIZE +: DSIZE];
  assign w_last_in = s_tlast[r_grant];
  assign w_push    = r_state == LOCK && s_tvalid[r_grant] && r_cnt != 2'd2;
  assign w_pop     = r_cnt != 2'd0 && m_tready;

  // first requester at or after ptr, wrapping modulo NUM
  always_comb begin
    w_sel = r_ptr;
    w_any = 1'b0;
    w_idx = '0;
    for (int k = 0; k < NUM; k++) begin
      w_idx = IDSIZE'((int'(r_ptr) + k) % NUM);
      if (!w_any && s_tvalid[w_idx]) begin
        w_sel = w_idx;
        w_any = 1'b1;
      end
    end
  end

  assign w_state_nxt = (r_state == IDLE) ? (w_any ? LOCK : IDLE)
                                         : ((w_push && w_last_in) ? IDLE : LOCK);

  always_comb begin
    s_tready = '0;
    if (r_state == LOCK && r_cnt != 2'd2) s_tready[r_grant] = 1'b1;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_grant   <= '0;
      r_pkt_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_any) r_grant <= w_sel;
      if (w_push && w_last_in) begin
        r_ptr     <= IDSIZE'((int'(r_grant) + 1) % NUM);
        r_pkt_cnt <= r_pkt_cnt + 16'd1;
      end
    end
  end

  // the tail slot is head when empty and the other slot when one entry is held
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_head   <= 1'b0;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else begin
      if (w_push) r_mem[r_head ^ r_cnt[0]] <= {w_last_in, w_data_in};
      if (w_pop) r_head <= ~r_head;
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
    end
  end

  assign m_tvalid            = r_cnt != 2'd0;
  assign {m_tlast, m_tdata}  = r_mem[r_head];
  assign busy                = r_state == LOCK;
  assign grant_id            = r_grant;
  assign pkt_cnt             = r_pkt_cnt;
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: directed vector table plus hand-written corner sequences for axis_rr_arbiter
module tb_axis_rr_arbiter;
  logic        clock = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] s_tdata;
  logic [3:0]  s_tvalid, s_tlast, s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tlast, m_tready;
  logic [1:0]  grant_id;
  logic        busy;
  logic [15:0] pkt_cnt;
  int          n_pass = 0;
  int          n_tot = 0;

  axis_rr_arbiter #(.NUM(4), .DSIZE(8), .IDSIZE(2)) dut (
    .clock(clock), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready), .grant_id(grant_id), .busy(busy), .pkt_cnt(pkt_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  tv, tl;
    logic [31:0] td;
    logic        mr;
    logic [3:0]  rdy;
    logic        mv;
    logic [7:0]  md;
    logic        ml;
    logic [1:0]  gid;
    logic        bsy;
    logic [15:0] pkt;
  } vec_t;

  vec_t vt [23];

  function automatic vec_t mk(input logic [3:0] tv, tl, input logic [31:0] td, input logic mr,
                              input logic [3:0] rdy, input logic mv, input logic [7:0] md,
                              input logic ml, input logic [1:0] gid, input logic bsy,
                              input logic [15:0] pkt);
    vec_t r;
    r.tv = tv; r.tl = tl; r.td = td; r.mr = mr; r.rdy = rdy; r.mv = mv;
    r.md = md; r.ml = ml; r.gid = gid; r.bsy = bsy; r.pkt = pkt;
    return r;
  endfunction

  // requester i presents byte {i, tlast_i}
  function automatic logic [31:0] rrd(input logic [3:0] tl);
    return {7'h18, tl[3], 7'h10, tl[2], 7'h08, tl[1], 7'h00, tl[0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b1;
    rst = 1'b1;
    #2;
    chk("rst_rdy", s_tready, 0);
    chk("rst_mv", m_tvalid, 0);
    chk("rst_md", m_tdata, 0);
    chk("rst_ml", m_tlast, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_pkt", pkt_cnt, 0);
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic run_vec(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      s_tvalid = vt[i].tv; s_tlast = vt[i].tl; s_tdata = vt[i].td; m_tready = vt[i].mr;
      #3;
      chk($sformatf("v%0d_rdy", i), s_tready, vt[i].rdy);
      chk($sformatf("v%0d_mv", i), m_tvalid, vt[i].mv);
      if (vt[i].mv) begin
        chk($sformatf("v%0d_md", i), m_tdata, vt[i].md);
        chk($sformatf("v%0d_ml", i), m_tlast, vt[i].ml);
      end
      chk($sformatf("v%0d_gid", i), grant_id, vt[i].gid);
      chk($sformatf("v%0d_busy", i), busy, vt[i].bsy);
      chk($sformatf("v%0d_pkt", i), pkt_cnt, vt[i].pkt);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int beat, got, dcnt;
    logic [7:0] hold;
    logic vld2;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b1;
    // single requester 1, four beats
    vt[0]  = mk(4'b0010, 4'b0000, 32'h0000_1100, 1, 4'b0000, 0, 8'h00, 0, 0, 0, 0);
    vt[1]  = mk(4'b0010, 4'b0000, 32'h0000_1100, 1, 4'b0010, 0, 8'h00, 0, 1, 1, 0);
    vt[2]  = mk(4'b0010, 4'b0000, 32'h0000_1200, 1, 4'b0010, 1, 8'h11, 0, 1, 1, 0);
    vt[3]  = mk(4'b0010, 4'b0000, 32'h0000_1300, 1, 4'b0010, 1, 8'h12, 0, 1, 1, 0);
    vt[4]  = mk(4'b0010, 4'b0010, 32'h0000_1400, 1, 4'b0010, 1, 8'h13, 0, 1, 1, 0);
    vt[5]  = mk(4'b0000, 4'b0000, 32'h0000_0000, 1, 4'b0000, 1, 8'h14, 1, 1, 0, 1);
    vt[6]  = mk(4'b0000, 4'b0000, 32'h0000_0000, 1, 4'b0000, 0, 8'h00, 0, 1, 0, 1);
    // all four requesters, two-beat packets, round robin from ptr 0
    vt[7]  = mk(4'hF, 4'b0000, rrd(4'b0000), 1, 4'b0000, 0, 8'h00, 0, 0, 0, 0);
    vt[8]  = mk(4'hF, 4'b0000, rrd(4'b0000), 1, 4'b0001, 0, 8'h00, 0, 0, 1, 0);
    vt[9]  = mk(4'hF, 4'b0001, rrd(4'b0001), 1, 4'b0001, 1, 8'h00, 0, 0, 1, 0);
    vt[10] = mk(4'hF, 4'b0000, rrd(4'b0000), 1, 4'b0000, 1, 8'h01, 1, 0, 0, 1);
    vt[11] = mk(4'hF, 4'b0000, rrd(4'b0000), 1, 4'b0010, 0, 8'h00, 0, 1, 1, 1);
    vt[12] = mk(4'hF, 4'b0010, rrd(4'b0010), 1, 4'b0010, 1, 8'h10, 0, 1, 1, 1);
    vt[13] = mk(4'hF, 4'b0000, rrd(4'b0000), 1, 4'b0000, 1, 8'h11, 1, 1, 0, 2);
    vt[14] = mk(4'hF, 4'b0000, rrd(4'b0000), 1, 4'b0100, 0, 8'h00, 0, 2, 1, 2);
    vt[15] = mk(4'hF, 4'b0100, rrd(4'b0100), 1, 4'b0100, 1, 8'h20, 0, 2, 1, 2);
    vt[16] = mk(4'hF, 4'b0000, rrd(4'b0000), 1, 4'b0000, 1, 8'h21, 1, 2, 0, 3);
    vt[17] = mk(4'hF, 4'b0000, rrd(4'b0000), 1, 4'b1000, 0, 8'h00, 0, 3, 1, 3);
    vt[18] = mk(4'hF, 4'b1000, rrd(4'b1000), 1, 4'b1000, 1, 8'h30, 0, 3, 1, 3);
    vt[19] = mk(4'hF, 4'b0000, rrd(4'b0000), 1, 4'b0000, 1, 8'h31, 1, 3, 0, 4);
    vt[20] = mk(4'hF, 4'b0000, rrd(4'b0000), 1, 4'b0001, 0, 8'h00, 0, 0, 1, 4);
    vt[21] = mk(4'hF, 4'b0001, rrd(4'b0001), 1, 4'b0001, 1, 8'h00, 0, 0, 1, 4);
    vt[22] = mk(4'hF, 4'b0000, rrd(4'b0000), 1, 4'b0000, 1, 8'h01, 1, 0, 0, 5);
    #1;
    do_reset();
    run_vec(0, 6);
    do_reset();
    run_vec(7, 22);

    // backpressure: requester 3 sends 8 beats, m_tready low for 5 cycles
    do_reset();
    beat = 0; got = 0; hold = '0;
    for (int cy = 0; cy < 60 && got < 8; cy++) begin
      s_tvalid = (beat < 8) ? 4'b1000 : 4'b0000;
      s_tlast = (beat == 7) ? 4'b1000 : 4'b0000;
      s_tdata = {8'(8'h80 + beat), 24'h0};
      m_tready = !(cy >= 5 && cy <= 9);
      #3;
      if (cy == 5) hold = m_tdata;
      if (cy >= 6 && cy <= 9) begin
        chk("bp_rdy_stall", s_tready, 0);
        chk("bp_hold", m_tdata, hold);
        chk("bp_mv_stall", m_tvalid, 1);
      end
      if (s_tvalid[3] && s_tready[3]) beat++;
      if (m_tvalid && m_tready) begin
        chk("bp_data", m_tdata, 8'(8'h80 + got));
        chk("bp_last", m_tlast, got == 7);
        got++;
      end
      tick();
    end
    chk("bp_beats", got, 8);
    chk("bp_pkt", pkt_cnt, 1);

    // grant hold: requester 2 pauses mid-packet while requester 0 waits
    do_reset();
    s_tvalid = 4'b0010; s_tlast = 4'b0010; s_tdata = 32'h0000_5500;
    tick();
    #3;
    chk("gh_r1_rdy", s_tready, 4'b0010);
    tick();
    beat = 0; dcnt = 0;
    for (int cy = 0; cy < 40 && beat < 4; cy++) begin
      vld2 = !(beat == 2 && dcnt < 3);
      s_tvalid = {1'b0, vld2, 1'b0, 1'b1};
      s_tlast = {1'b0, beat == 3, 1'b0, 1'b1};
      s_tdata = {8'h00, 8'(8'h40 + beat), 8'h00, 8'h0A};
      #3;
      if (!vld2) begin
        chk("gh_gid", grant_id, 2);
        chk("gh_busy", busy, 1);
        chk("gh_rdy", s_tready, 4'b0100);
        dcnt++;
      end
      if (vld2 && s_tready[2]) beat++;
      tick();
    end
    chk("gh_beats", beat, 4);
    s_tvalid = 4'b0001; s_tlast = 4'b0001; s_tdata = 32'h0000_000A;
    #3;
    chk("gh_idle_busy", busy, 0);
    chk("gh_idle_rdy", s_tready, 0);
    tick();
    #3;
    chk("gh_next_gid", grant_id, 0);
    chk("gh_next_rdy", s_tready, 4'b0001);
    tick();
    s_tvalid = '0; s_tlast = '0;
    #3;
    chk("gh_pkt", pkt_cnt, 3);
    tick();

    // reset on beat 3 of a 6-beat packet from requester 0
    beat = 0;
    for (int cy = 0; cy < 20 && beat < 3; cy++) begin
      s_tvalid = 4'b0001; s_tlast = 4'b0000; s_tdata = {24'h0, 8'(8'h60 + beat)};
      #3;
      if (s_tready[0]) beat++;
      tick();
    end
    s_tdata = {24'h0, 8'h63};
    #1;
    chk("mr_pre_rdy", s_tready, 4'b0001);
    chk("mr_pre_pkt", pkt_cnt, 3);
    rst = 1'b1;
    #1;
    chk("mr_rdy", s_tready, 0);
    chk("mr_mv", m_tvalid, 0);
    chk("mr_md", m_tdata, 0);
    chk("mr_ml", m_tlast, 0);
    chk("mr_busy", busy, 0);
    chk("mr_gid", grant_id, 0);
    chk("mr_pkt", pkt_cnt, 0);
    tick();
    rst = 1'b0;
    s_tvalid = 4'b0011; s_tlast = 4'b0011; s_tdata = 32'h0000_7170;
    #3;
    chk("mr_idle_rdy", s_tready, 0);
    tick();
    #3;
    chk("mr_win_gid", grant_id, 0);
    chk("mr_win_rdy", s_tready, 4'b0001);
    tick();
    s_tvalid = '0; s_tlast = '0;
    #3;
    chk("mr_pkt_after", pkt_cnt, 1);
    tick();

    // packet counter wrap, preloaded near the top of its range
    force dut.r_pkt_cnt = 16'hFFFE;
    #1;
    release dut.r_pkt_cnt;
    #1;
    chk("wr_preload", pkt_cnt, 16'hFFFE);
    s_tvalid = 4'b0001; s_tlast = 4'b0001; s_tdata = 32'h0000_00EE;
    tick();
    tick();
    #2;
    chk("wr_ffff", pkt_cnt, 16'hFFFF);
    tick();
    tick();
    #2;
    chk("wr_zero", pkt_cnt, 16'h0000);
    s_tvalid = '0; s_tlast = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
